// File: rtl/aes_pkg.sv
// Shared AES arithmetic: GF(2^8) helpers, S-box, MixColumns column, Rcon and FSM encoding.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      MIX  = 2'd2,
      DONE = 2'd3
   } fsm_t;

   function automatic int nr_of(input int key_bits);
      return (key_bits == 256) ? 14 : 10;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         acc = acc ^ (b[i] ? p : 8'h00);
         p   = xtime(p);
      end
      return acc;
   endfunction

   // S-box computed as multiplicative inverse (a^254, so 0 maps to 0) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] inv;
      p   = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_enc_iter_if.sv
// Block-in / block-out valid-ready bus of the iterative AES core.
interface aes_enc_iter_if #(
   parameter int KEY_BITS = 128
);
   logic                in_valid;
   logic                in_ready;
   logic [127:0]        plaintext;
   logic [KEY_BITS-1:0] key;
   logic                out_valid;
   logic                out_ready;
   logic [127:0]        ciphertext;

   modport master (
      output in_valid, plaintext, key, out_ready,
      input  in_ready, out_valid, ciphertext
   );

   modport slave (
      input  in_valid, plaintext, key, out_ready,
      output in_ready, out_valid, ciphertext
   );
endinterface

// File: rtl/aes_round_key_gen.sv
// On-the-fly AES key expansion: a KEY_BITS window of the most recent schedule words,
// presenting the round key for the current MIX cycle and stepping on each advance.
module aes_round_key_gen
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                advance,
   input  logic [KEY_BITS-1:0] key,
   output logic [127:0]        round_key
);
   localparam bit IS256 = (KEY_BITS == 256);

   logic [KEY_BITS-1:0] win;
   logic [KEY_BITS-1:0] win_adv;
   logic [3:0]          rc_idx;
   logic                first;
   logic                phase;
   logic [127:0]        prev;
   logic [31:0]         temp;
   logic [127:0]        next4;

   // Next four schedule words; for 256-bit keys, phase selects the SubWord-only step (i%8==4)
   always_comb begin
      prev = win[KEY_BITS-1 -: 128];
      if (IS256 && phase) begin
         temp = sub_word(win[31:0]);
      end else begin
         temp = sub_word(rot_word(win[31:0])) ^ {rcon(rc_idx), 24'h000000};
      end
      next4[127:96] = prev[127:96] ^ temp;
      next4[95:64]  = prev[95:64]  ^ next4[127:96];
      next4[63:32]  = prev[63:32]  ^ next4[95:64];
      next4[31:0]   = prev[31:0]   ^ next4[63:32];
      if (IS256 && first) begin
         round_key = win[127:0];
      end else begin
         round_key = next4;
      end
   end

   if (IS256) begin : g_shift
      assign win_adv = {win[127:0], next4};
   end else begin : g_replace
      assign win_adv = next4;
   end

   // Schedule window, Rcon index and 256-bit step bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         win    <= '0;
         rc_idx <= 4'd0;
         first  <= 1'b0;
         phase  <= 1'b0;
      end else if (load) begin
         win    <= key;
         rc_idx <= 4'd0;
         first  <= IS256;
         phase  <= 1'b0;
      end else if (advance) begin
         if (IS256 && first) begin
            first <= 1'b0;
         end else begin
            win    <= win_adv;
            phase  <= IS256 ? ~phase : 1'b0;
            rc_idx <= (IS256 && phase) ? rc_idx : rc_idx + 4'd1;
         end
      end
   end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 encryption core: SBOX_LANES bytes substituted per SUB cycle,
// one MIX cycle per round (ShiftRows, MixColumns, AddRoundKey), valid/ready on both sides.
module aes_enc_iter
   import aes_pkg::*;
#(
   parameter int KEY_BITS   = 128,
   parameter int SBOX_LANES = 4
) (
   input  logic           clk,
   input  logic           rst,
   aes_enc_iter_if.slave  bus
);
   localparam int         SUBC     = 16 / SBOX_LANES;
   localparam logic [3:0] NR_W     = 4'(nr_of(KEY_BITS));
   localparam logic [3:0] CNT_LAST = 4'(SUBC - 1);

   if (!(KEY_BITS == 128 || KEY_BITS == 256)) begin : g_bad_key_bits
      $error("aes_enc_iter: KEY_BITS must be 128 or 256");
   end
   if (!(SBOX_LANES == 4 || SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
      $error("aes_enc_iter: SBOX_LANES must be 4, 8 or 16");
   end

   fsm_t         fsm;
   fsm_t         fsm_next;
   logic         load;
   logic         advance;
   logic [127:0] st;
   logic [3:0]   round;
   logic [3:0]   cnt;
   logic [127:0] rk;
   logic [127:0] chunk;
   logic [7:0]   lane_out [SBOX_LANES];
   logic [127:0] sub_st;
   logic [127:0] sr;
   logic [127:0] mc;
   logic [127:0] mix_st;

   aes_round_key_gen #(.KEY_BITS(KEY_BITS)) u_key_gen (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .advance   (advance),
      .key       (bus.key),
      .round_key (rk)
   );

   assign bus.in_ready   = (fsm == IDLE);
   assign bus.out_valid  = (fsm == DONE);
   assign bus.ciphertext = st;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm <= IDLE;
      end else begin
         fsm <= fsm_next;
      end
   end

   // Next-state decode plus key-schedule strobes
   always_comb begin
      fsm_next = fsm;
      load     = 1'b0;
      advance  = 1'b0;
      case (fsm)
         IDLE: begin
            if (bus.in_valid) begin
               fsm_next = SUB;
               load     = 1'b1;
            end else begin
               fsm_next = IDLE;
            end
         end
         SUB: begin
            if (cnt == CNT_LAST) begin
               fsm_next = MIX;
            end else begin
               fsm_next = SUB;
            end
         end
         MIX: begin
            advance = 1'b1;
            if (round == NR_W) begin
               fsm_next = DONE;
            end else begin
               fsm_next = SUB;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               fsm_next = IDLE;
            end else begin
               fsm_next = DONE;
            end
         end
         default: fsm_next = IDLE;
      endcase
   end

   // SUB step: bring the cnt-th group of SBOX_LANES bytes to the top, run it through the lanes
   always_comb begin
      chunk  = st << (int'(cnt) * SBOX_LANES * 8);
      sub_st = st;
      for (int j = 0; j < SBOX_LANES; j++) begin
         lane_out[j] = sbox(chunk[127 - 8*j -: 8]);
      end
      for (int b = 0; b < 16; b++) begin
         sub_st[127 - 8*b -: 8] = ((b / SBOX_LANES) == int'(cnt)) ? lane_out[b % SBOX_LANES]
                                                                  : st[127 - 8*b -: 8];
      end
   end

   // MIX step: ShiftRows, MixColumns (not in the final round), AddRoundKey
   always_comb begin
      sr = '0;
      mc = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[127 - 8*(4*c + r) -: 8] = st[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[127 - 32*c -: 32] = (round == NR_W) ? sr[127 - 32*c -: 32]
                                                : mix_column(sr[127 - 32*c -: 32]);
      end
      mix_st = mc ^ rk;
   end

   // State datapath and round/byte-group counters
   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= '0;
         round <= 4'd0;
         cnt   <= 4'd0;
      end else begin
         case (fsm)
            IDLE: begin
               if (bus.in_valid) begin
                  st    <= bus.plaintext ^ bus.key[KEY_BITS-1 -: 128];
                  round <= 4'd1;
                  cnt   <= 4'd0;
               end
            end
            SUB: begin
               st  <= sub_st;
               cnt <= cnt + 4'd1;
            end
            MIX: begin
               st  <= mix_st;
               cnt <= 4'd0;
               if (round != NR_W) begin
                  round <= round + 4'd1;
               end
            end
            DONE: begin
               st <= st;
            end
            default: begin
               st <= st;
            end
         endcase
      end
   end

endmodule
